dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: FIXED_PRIO, 0, 0 = round-robin between ports, 1 = port 0 always wins ties.
REQ-002 Port: clk  input  1  single clock; all state on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Ports, per requester N in {0,1}:
- pN_req  input  1  access request, held until grant
- pN_we  input  1  1 = store, 0 = load
- pN_addr  input  32  byte address
- pN_wdata  input  32  store data, LSB-justified
- pN_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- pN_unsigned  input  1  zero-extend load when 1
REQ-005 Ports, per requester N, responses:
- pN_gnt  output  1  request accepted this cycle
- pN_rvalid  output  1  one-cycle response pulse
- pN_rdata  output  32  aligned, extended load data
- pN_err  output  1  misaligned or illegal; valid with rvalid
REQ-006 Memory-side ports:
- mem_we  output  1  write enable
- mem_a  output  32  byte address
- mem_wd  output  32  lane-positioned write data
- mem_write_mask  output  32  bit-level write mask
- mem_rd  input  32  combinational read data for mem_a

Function
REQ-007 FSM states IDLE and ACCESS; IDLE -> ACCESS on any grant; ACCESS -> IDLE unconditionally after one cycle.
REQ-008 In IDLE, the block shall assert exactly one pN_gnt, combinationally, when at least one pN_req is high; no grant in ACCESS.
REQ-009 At the grant edge, the block shall latch port id, we, addr, wdata, size and unsigned; requester may change inputs from the next cycle.
REQ-010 Round-robin: on simultaneous requests, grant the port not granted most recently; a lone requester is always granted.
REQ-011 FIXED_PRIO=1: port 0 wins every tie; port 1 is granted only when p0_req is low.
REQ-012 In ACCESS, mem_a shall equal the latched addr; outside ACCESS, mem_a holds its last value and mem_we = 0.
REQ-013 Byte mask = 0x000000FF << (8*addr[1:0]); half mask = 0x0000FFFF << (16*addr[1]); word mask = 0xFFFFFFFF.
REQ-014 mem_wd: byte = wdata[7:0] replicated on 4 lanes, half = wdata[15:0] replicated on 2 lanes, word = wdata.
REQ-015 Illegal access: size 11, half with addr[0]=1, or word with addr[1:0]!=00; mem_we = 0 and mem_write_mask = 0.
REQ-016 mem_we = 1 only in ACCESS for a legal store.
REQ-017 At the end of ACCESS, the block shall register the response; the granted port's rvalid pulses for exactly the following cycle, 2 cycles after gnt.
REQ-018 Load data extraction:
- select the lane by addr[1:0] or addr[1]
- sign-extend unless unsigned
- word data passes unchanged
REQ-019 Store response: rdata = 0, err = 0; illegal access response: rdata = 0, err = 1.
REQ-020 rdata/err hold until that port's next rvalid.
REQ-021 A new grant is allowed in the cycle rvalid is high; peak throughput is one access per 2 cycles.
REQ-022 A requester that drops req before gnt is not served, and the round-robin pointer is not updated.

Reset
REQ-023 While reset is high:
- state = IDLE
- all gnt, rvalid, err, mem_we = 0
- all rdata, mem_a, mem_wd, mem_write_mask = 0
- round-robin last-granted = port 1, so port 0 wins the first tie
REQ-024 Reset asserted during ACCESS shall drop mem_we immediately, with no rvalid for the aborted access.

Verification
REQ-025 p0 store word 0xDEADBEEF @0x100, then p0 load word @0x100 -> first rvalid 2 cycles after gnt, err = 0; second rdata = 0xDEADBEEF.
REQ-026 Store byte 0xA5 @0x103 -> mem_write_mask = 0xFF000000, mem_wd = 0xA5A5A5A5; then load byte signed @0x103 -> rdata = 0xFFFFFFA5, unsigned -> 0x000000A5.
REQ-027 Load half @0x101 -> err = 1, rdata = 0, mem_we never 1; size 11 store -> err = 1, no write.
REQ-028 p0 and p1 both request continuously, FIXED_PRIO=0 -> grants alternate p0, p1, p0, p1; FIXED_PRIO=1 -> only p0 granted.
REQ-029 Assert reset in the ACCESS cycle of a store -> mem_we falls without a clock edge, no rvalid; after release, first tie goes to p0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: grants one requester per access, drives byte/half/word
// lane masks toward a single-port memory and returns aligned, extended load data.
module dmem_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [1:0]  p0_size,
    input  logic        p0_unsigned,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [1:0]  p1_size,
    input  logic        p1_unsigned,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic [31:0] mem_write_mask,
    input  logic [31:0] mem_rd
);

    localparam int unsigned DW = 32;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t          state_q, state_d;
    logic            last_q;
    logic            port_q;
    logic            we_q;
    logic [DW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [1:0]      size_q;
    logic            uns_q;

    logic            grant_p1_c;
    logic            legal_c;
    logic [DW-1:0]   mask_c;
    logic [DW-1:0]   rd_byte_sh_c;
    logic [DW-1:0]   rd_half_sh_c;
    logic [DW-1:0]   load_c;
    logic [DW-1:0]   resp_c;

    // last_q = 1 means port 1 was granted most recently, so port 0 wins the next tie
    assign grant_p1_c = p1_req && (!p0_req || (!FIXED_PRIO && !last_q));

    always_comb begin
        legal_c = 1'b0;
        mask_c  = '0;
        mem_wd  = wdata_q;
        case (size_q)
            2'b00: begin
                legal_c = 1'b1;
                mask_c  = DW'(32'h0000_00FF) << {addr_q[1:0], 3'b000};
                mem_wd  = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                legal_c = !addr_q[0];
                mask_c  = DW'(32'h0000_FFFF) << {addr_q[1], 4'b0000};
                mem_wd  = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                legal_c = (addr_q[1:0] == 2'b00);
                mask_c  = '1;
            end
            default: legal_c = 1'b0;
        endcase
    end

    // Lane selection and sign/zero extension for loads
    always_comb begin
        rd_byte_sh_c = mem_rd >> {addr_q[1:0], 3'b000};
        rd_half_sh_c = mem_rd >> {addr_q[1], 4'b0000};
        case (size_q)
            2'b00:   load_c = uns_q ? {24'b0, rd_byte_sh_c[7:0]}
                                    : {{24{rd_byte_sh_c[7]}}, rd_byte_sh_c[7:0]};
            2'b01:   load_c = uns_q ? {16'b0, rd_half_sh_c[15:0]}
                                    : {{16{rd_half_sh_c[15]}}, rd_half_sh_c[15:0]};
            default: load_c = mem_rd;
        endcase
        resp_c = (legal_c && !we_q) ? load_c : '0;
    end

    assign mem_a          = addr_q;
    assign mem_write_mask = (state_q == ACCESS && legal_c && we_q) ? mask_c : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state plus the combinational grant and write strobe
    always_comb begin
        state_d = state_q;
        p0_gnt  = 1'b0;
        p1_gnt  = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset && (p0_req || p1_req)) begin
                    state_d = ACCESS;
                    if (grant_p1_c) p1_gnt = 1'b1;
                    else            p0_gnt = 1'b1;
                end
            end
            ACCESS: begin
                state_d = IDLE;
                mem_we  = we_q && legal_c;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture at the grant edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q  <= 1'b1;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
        end else if (p0_gnt || p1_gnt) begin
            last_q  <= p1_gnt;
            port_q  <= p1_gnt;
            we_q    <= p1_gnt ? p1_we       : p0_we;
            addr_q  <= p1_gnt ? p1_addr     : p0_addr;
            wdata_q <= p1_gnt ? p1_wdata    : p0_wdata;
            size_q  <= p1_gnt ? p1_size     : p0_size;
            uns_q   <= p1_gnt ? p1_unsigned : p0_unsigned;
        end
    end

    // Response registered at the end of ACCESS; data/err hold until the port's next response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            p0_err    <= 1'b0;
            p1_err    <= 1'b0;
        end else begin
            p0_rvalid <= (state_q == ACCESS) && !port_q;
            p1_rvalid <= (state_q == ACCESS) && port_q;
            if (state_q == ACCESS) begin
                if (port_q) begin
                    p1_rdata <= resp_c;
                    p1_err   <= !legal_c;
                end else begin
                    p0_rdata <= resp_c;
                    p0_err   <= !legal_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance backed by a small memory
// model, plus a fixed-priority instance sharing the same requests.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p0_req = 0, p0_we = 0, p0_unsigned = 0;
    logic [31:0] p0_addr = 0, p0_wdata = 0;
    logic [1:0]  p0_size = 0;
    logic        p1_req = 0, p1_we = 0, p1_unsigned = 0;
    logic [31:0] p1_addr = 0, p1_wdata = 0;
    logic [1:0]  p1_size = 0;

    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err, mem_we;
    logic [31:0] p0_rdata, p1_rdata, mem_a, mem_wd, mem_write_mask, mem_rd;

    logic        f0_gnt, f0_rvalid, f0_err, f1_gnt, f1_rvalid, f1_err, f_mem_we;
    logic [31:0] f0_rdata, f1_rdata, f_mem_a, f_mem_wd, f_mem_write_mask;

    logic [31:0] mem [0:255];
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic        g;
        logic        mwe;
        logic [31:0] mask, wd, ma;
        logic        rv_acc, rv, rv_next;
        logic [31:0] rd;
        logic        er;
    } obs_t;

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[9:2]];

    always @(posedge clk)
        if (mem_we)
            mem[mem_a[9:2]] <= (mem[mem_a[9:2]] & ~mem_write_mask) | (mem_wd & mem_write_mask);

    dmem_arbiter #(.FIXED_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_size(p0_size), .p0_unsigned(p0_unsigned),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_size(p1_size), .p1_unsigned(p1_unsigned),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_write_mask(mem_write_mask), .mem_rd(mem_rd)
    );

    dmem_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_size(p0_size), .p0_unsigned(p0_unsigned),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_size(p1_size), .p1_unsigned(p1_unsigned),
        .p0_gnt(f0_gnt), .p0_rvalid(f0_rvalid), .p0_rdata(f0_rdata), .p0_err(f0_err),
        .p1_gnt(f1_gnt), .p1_rvalid(f1_rvalid), .p1_rdata(f1_rdata), .p1_err(f1_err),
        .mem_we(f_mem_we), .mem_a(f_mem_a), .mem_wd(f_mem_wd),
        .mem_write_mask(f_mem_write_mask), .mem_rd(mem_rd)
    );

    // Drive one request, scramble inputs after the grant edge, capture what each phase shows
    task automatic issue(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size,
                         input logic uns, output obs_t o);
        @(negedge clk);
        if (port) begin
            p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_size = size;
            p1_unsigned = uns; p1_req = 1'b1;
        end else begin
            p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_size = size;
            p0_unsigned = uns; p0_req = 1'b1;
        end
        #1 o.g = port ? p1_gnt : p0_gnt;
        @(posedge clk); #1;
        p0_req = 0; p1_req = 0;
        p0_addr = 32'hFFFF_FFFF; p1_addr = 32'hFFFF_FFFF;
        p0_wdata = 32'h5555_5555; p1_wdata = 32'h5555_5555;
        p0_size = 2'b11; p1_size = 2'b11; p0_we = ~we; p1_we = ~we;
        o.mwe = mem_we; o.mask = mem_write_mask; o.wd = mem_wd; o.ma = mem_a;
        o.rv_acc = port ? p1_rvalid : p0_rvalid;
        @(posedge clk); #1;
        o.rv = port ? p1_rvalid : p0_rvalid;
        o.rd = port ? p1_rdata : p0_rdata;
        o.er = port ? p1_err : p0_err;
        @(posedge clk); #1;
        o.rv_next = port ? p1_rvalid : p0_rvalid;
    endtask

    task automatic test_reset();
        p0_req = 1; p1_req = 1;
        #3;
        checks++; if ({p0_gnt, p1_gnt} !== 2'b00) begin errors++; $display("FAIL rst_gnt got=%b exp=00", {p0_gnt, p1_gnt}); end
        checks++; if ({p0_rvalid, p1_rvalid, p0_err, p1_err, mem_we} !== 5'b0) begin errors++; $display("FAIL rst_flags got=%b exp=00000", {p0_rvalid, p1_rvalid, p0_err, p1_err, mem_we}); end
        checks++; if ((p0_rdata | p1_rdata | mem_a | mem_wd | mem_write_mask) !== 32'h0) begin errors++; $display("FAIL rst_buses got=%h exp=0", p0_rdata | p1_rdata | mem_a | mem_wd | mem_write_mask); end
        @(negedge clk); p0_req = 0; p1_req = 0; reset = 0;
    endtask

    task automatic test_word();
        obs_t o;
        issue(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 2'b10, 1'b0, o);
        checks++; if (o.g !== 1'b1) begin errors++; $display("FAIL st_word_gnt got=%b exp=1", o.g); end
        checks++; if ({o.mwe, o.ma, o.mask, o.wd} !== {1'b1, 32'h100, 32'hFFFF_FFFF, 32'hDEAD_BEEF}) begin errors++; $display("FAIL st_word_mem got=%b %h %h %h exp=1 00000100 ffffffff deadbeef", o.mwe, o.ma, o.mask, o.wd); end
        checks++; if ({o.rv_acc, o.rv, o.rv_next} !== 3'b010) begin errors++; $display("FAIL st_word_rvalid_timing got=%b exp=010", {o.rv_acc, o.rv, o.rv_next}); end
        checks++; if ({o.rd, o.er} !== {32'h0, 1'b0}) begin errors++; $display("FAIL st_word_resp got=%h/%b exp=00000000/0", o.rd, o.er); end
        issue(1'b0, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, o);
        checks++; if ({o.rv, o.rd, o.er, o.mwe} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin errors++; $display("FAIL ld_word got=%b %h %b we=%b exp=1 deadbeef 0 we=0", o.rv, o.rd, o.er, o.mwe); end
    endtask

    task automatic test_subword();
        obs_t o;
        issue(1'b0, 1'b1, 32'h103, 32'h0000_00A5, 2'b00, 1'b0, o);
        checks++; if ({o.mwe, o.mask, o.wd} !== {1'b1, 32'hFF00_0000, 32'hA5A5_A5A5}) begin errors++; $display("FAIL st_byte got=%b %h %h exp=1 ff000000 a5a5a5a5", o.mwe, o.mask, o.wd); end
        issue(1'b0, 1'b0, 32'h103, 32'h0, 2'b00, 1'b0, o);
        checks++; if ({o.rd, o.er} !== {32'hFFFF_FFA5, 1'b0}) begin errors++; $display("FAIL ld_byte_signed got=%h/%b exp=ffffffa5/0", o.rd, o.er); end
        issue(1'b0, 1'b0, 32'h103, 32'h0, 2'b00, 1'b1, o);
        checks++; if (o.rd !== 32'h0000_00A5) begin errors++; $display("FAIL ld_byte_unsigned got=%h exp=000000a5", o.rd); end
        issue(1'b1, 1'b0, 32'h102, 32'h0, 2'b01, 1'b0, o);
        checks++; if ({o.g, o.rv, o.rd} !== {1'b1, 1'b1, 32'hFFFF_A5AD}) begin errors++; $display("FAIL p1_ld_half got=%b %b %h exp=1 1 ffffa5ad", o.g, o.rv, o.rd); end
        issue(1'b1, 1'b1, 32'h102, 32'h0000_1234, 2'b01, 1'b0, o);
        checks++; if ({o.mask, o.wd} !== {32'hFFFF_0000, 32'h1234_1234}) begin errors++; $display("FAIL p1_st_half got=%h %h exp=ffff0000 12341234", o.mask, o.wd); end
    endtask

    task automatic test_illegal();
        obs_t o;
        issue(1'b0, 1'b0, 32'h101, 32'h0, 2'b01, 1'b0, o);
        checks++; if ({o.rv, o.er, o.rd, o.mwe} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin errors++; $display("FAIL ld_half_misaligned got=%b %b %h we=%b exp=1 1 00000000 we=0", o.rv, o.er, o.rd, o.mwe); end
        issue(1'b0, 1'b1, 32'h100, 32'h1111_1111, 2'b11, 1'b0, o);
        checks++; if ({o.er, o.mwe, o.mask} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL st_size11 got=%b we=%b mask=%h exp=1 we=0 mask=00000000", o.er, o.mwe, o.mask); end
        issue(1'b1, 1'b1, 32'h102, 32'h2222_2222, 2'b10, 1'b0, o);
        checks++; if ({o.er, o.mwe, o.mask} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL st_word_misaligned got=%b we=%b mask=%h exp=1 we=0 mask=00000000", o.er, o.mwe, o.mask); end
        issue(1'b0, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, o);
        checks++; if ({o.rd, o.er} !== {32'h1234_BEEF, 1'b0}) begin errors++; $display("FAIL ld_after_illegal got=%h/%b exp=1234beef/0", o.rd, o.er); end
    endtask

    task automatic test_arbitration();
        logic [1:0] exp_rr;
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0;
        p0_we = 0; p1_we = 0; p0_size = 2'b10; p1_size = 2'b10;
        p0_addr = 32'h100; p1_addr = 32'h100;
        p0_req = 1; p1_req = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_rr = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if ({p1_gnt, p0_gnt} !== exp_rr) begin errors++; $display("FAIL rr_grant_%0d got={p1,p0}=%b exp=%b", k, {p1_gnt, p0_gnt}, exp_rr); end
            checks++; if ({f1_gnt, f0_gnt} !== 2'b01) begin errors++; $display("FAIL fixed_grant_%0d got={p1,p0}=%b exp=01", k, {f1_gnt, f0_gnt}); end
            @(posedge clk); #1;
            checks++; if ({p1_gnt, p0_gnt, f1_gnt, f0_gnt} !== 4'b0) begin errors++; $display("FAIL gnt_in_access_%0d got=%b exp=0000", k, {p1_gnt, p0_gnt, f1_gnt, f0_gnt}); end
            @(posedge clk);
        end
        #1 p0_req = 0; p1_req = 0;
        @(posedge clk); @(posedge clk);
    endtask

    task automatic test_drop();
        @(negedge clk);
        p0_we = 0; p0_size = 2'b10; p0_addr = 32'h100; p0_req = 1;
        @(posedge clk); #1;
        p0_req = 0; p1_req = 1; p1_we = 0; p1_size = 2'b10; p1_addr = 32'h100;
        checks++; if (p1_gnt !== 1'b0) begin errors++; $display("FAIL drop_gnt_access got=%b exp=0", p1_gnt); end
        @(negedge clk); p1_req = 0;
        @(posedge clk); #1;
        checks++; if ({p0_rvalid, p1_rvalid} !== 2'b10) begin errors++; $display("FAIL drop_rvalid got={p0,p1}=%b exp=10", {p0_rvalid, p1_rvalid}); end
        @(posedge clk); #1;
        checks++; if (p1_rvalid !== 1'b0) begin errors++; $display("FAIL drop_not_served got=%b exp=0", p1_rvalid); end
    endtask

    task automatic test_reset_in_access();
        @(negedge clk);
        p0_we = 1; p0_size = 2'b10; p0_addr = 32'h104; p0_wdata = 32'h1234_5678; p0_req = 1;
        @(posedge clk); #1;
        p0_req = 0;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL abort_we_before got=%b exp=1", mem_we); end
        #2 reset = 1;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL abort_we_async got=%b exp=0", mem_we); end
        @(posedge clk); #1;
        checks++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin errors++; $display("FAIL abort_rvalid got=%b exp=00", {p0_rvalid, p1_rvalid}); end
        @(posedge clk); #1;
        checks++; if (mem[65] !== 32'h0) begin errors++; $display("FAIL abort_no_write got=%h exp=00000000", mem[65]); end
        @(negedge clk);
        reset = 0; p0_we = 0; p1_we = 0; p0_req = 1; p1_req = 1;
        #1;
        checks++; if ({p1_gnt, p0_gnt} !== 2'b01) begin errors++; $display("FAIL post_reset_tie got={p1,p0}=%b exp=01", {p1_gnt, p0_gnt}); end
        @(posedge clk); #1 p0_req = 0; p1_req = 0;
        @(posedge clk); @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_word();
        test_subword();
        test_illegal();
        test_arbitration();
        test_drop();
        test_reset_in_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
